// File: rtl/order_frame_decoder.sv
// Frame decoder between UART_RX and the snack manager: sync, lo, hi, checksum.
// Good frames pulse cmd_valid with cmd_out = {hi,lo}. Bad or stalled frames pulse frame_err and are counted.
module order_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] cmd_out,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [7:0]  err_count,
  output logic        in_frame
);

  localparam int CW = ($clog2(TIMEOUT_CYCLES) > 17) ? $clog2(TIMEOUT_CYCLES) : 17;
  localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_CHECKSUM = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {S_SYNC, S_LO, S_HI, S_CHK} state_t;

  state_t        state, state_n;
  logic [7:0]    lo, lo_n, hi, hi_n;
  logic [CW-1:0] idle, idle_n;
  logic [15:0]   cmd_out_n;
  logic          cmd_valid_n, frame_err_n;
  logic [1:0]    err_code_n;
  logic [7:0]    err_count_n;
  logic          err_hit;
  logic [1:0]    err_cause;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    state_n     = state;
    lo_n        = lo;
    hi_n        = hi;
    idle_n      = idle;
    cmd_out_n   = cmd_out;
    cmd_valid_n = 1'b0;
    frame_err_n = 1'b0;
    err_code_n  = err_code;
    err_count_n = err_count;
    err_hit     = 1'b0;
    err_cause   = ERR_NONE;

    if (state == S_SYNC) begin
      idle_n = '0;
      if (rx_valid && rx_data == SYNC_BYTE) state_n = S_LO;
    end else if (rx_valid) begin
      // A byte on the timeout cycle wins: it is consumed and the idle count restarts.
      idle_n = '0;
      case (state)
        S_LO: begin
          lo_n    = rx_data;
          state_n = S_HI;
        end
        S_HI: begin
          hi_n    = rx_data;
          state_n = S_CHK;
        end
        default: begin
          state_n = S_SYNC;
          if (rx_data == (lo ^ hi)) begin
            cmd_out_n   = {hi, lo};
            cmd_valid_n = 1'b1;
          end else begin
            err_hit   = 1'b1;
            err_cause = ERR_CHECKSUM;
          end
        end
      endcase
    end else if (idle == IDLE_MAX) begin
      state_n   = S_SYNC;
      idle_n    = '0;
      err_hit   = 1'b1;
      err_cause = ERR_TIMEOUT;
    end else begin
      idle_n = idle + 1'b1;
    end

    if (err_hit) begin
      frame_err_n = 1'b1;
      err_code_n  = err_cause;
      err_count_n = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_SYNC;
      lo        <= '0;
      hi        <= '0;
      idle      <= '0;
      cmd_out   <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
      err_count <= '0;
    end else begin
      state     <= state_n;
      lo        <= lo_n;
      hi        <= hi_n;
      idle      <= idle_n;
      cmd_out   <= cmd_out_n;
      cmd_valid <= cmd_valid_n;
      frame_err <= frame_err_n;
      err_code  <= err_code_n;
      err_count <= err_count_n;
    end
  end

  assign in_frame = (state != S_SYNC);

endmodule

// File: tb/tb_order_frame_decoder.sv
// Randomized scoreboard bench for order_frame_decoder with a byte-list reference model.
// The driver feeds the model and queues expected events; a negedge monitor pops and compares them.
module tb_order_frame_decoder;

  localparam int         TIMEOUT = 16;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [15:0] cmd_out;
  logic        cmd_valid, frame_err;
  logic [1:0]  err_code;
  logic [7:0]  err_count;
  logic        in_frame;

  order_frame_decoder #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_out(cmd_out), .cmd_valid(cmd_valid), .frame_err(frame_err),
    .err_code(err_code), .err_count(err_count), .in_frame(in_frame)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    bit          is_err;
    logic [15:0] cmd;
    logic [1:0]  code;
    logic [7:0]  cnt;
    int          edge_idx;
  } ev_t;

  ev_t sb[$];

  // Reference model: the open frame is just the list of bytes collected so far.
  logic [7:0]  frame_q[$];
  int          gap = 0;
  logic [15:0] m_cmd = '0;
  logic [7:0]  m_cnt = '0;
  logic [1:0]  m_code = '0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input bit is_err, input int e);
    ev_t ev;
    ev.is_err = is_err; ev.cmd = m_cmd; ev.code = m_code; ev.cnt = m_cnt; ev.edge_idx = e;
    sb.push_back(ev);
  endtask

  task automatic model_err(input logic [1:0] code, input int e);
    m_code = code;
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    push_ev(1'b1, e);
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input int e);
    if (v) begin
      gap = 0;
      if (frame_q.size() == 0) begin
        if (d == SYNC) frame_q.push_back(d);
      end else begin
        frame_q.push_back(d);
        if (frame_q.size() == 4) begin
          if (d == (frame_q[1] ^ frame_q[2])) begin
            m_cmd = {frame_q[2], frame_q[1]};
            push_ev(1'b0, e);
          end else begin
            model_err(2'b01, e);
          end
          frame_q.delete();
        end
      end
    end else if (frame_q.size() != 0) begin
      gap++;
      if (gap == TIMEOUT) begin
        model_err(2'b10, e);
        frame_q.delete();
      end
    end
  endtask

  // One clock of stimulus; called at a negedge, returns at the next negedge.
  task automatic cycle(input bit v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    model_step(v, d, edge_n + 1);
    @(posedge clk);
    #1;
    check("in_frame", in_frame, frame_q.size() != 0);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int idle_before);
    repeat (idle_before) cycle(1'b0, 8'h00);
    cycle(1'b1, d);
  endtask

  task automatic send4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3, input int sp);
    send(b0, sp); send(b1, sp); send(b2, sp); send(b3, sp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    frame_q.delete();
    gap = 0; m_cmd = '0; m_cnt = '0; m_code = '0;
    @(posedge clk);
    #1;
    check("rst_cmd_out", cmd_out, 16'h0000);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_err_code", err_code, 2'b00);
    check("rst_err_count", err_count, 8'h00);
    check("rst_in_frame", in_frame, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every output pulse must match the next queued event, on the predicted edge.
  always @(negedge clk) begin
    if (!rst && (cmd_valid || frame_err)) begin
      if (cmd_valid && frame_err) check("pulse_exclusive", 1, 0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {cmd_valid, frame_err}, 0);
      end else begin
        ev_t ev;
        ev = sb.pop_front();
        check("ev_kind", frame_err, ev.is_err);
        check("ev_edge", edge_n, ev.edge_idx);
        check("cmd_out", cmd_out, ev.cmd);
        check("err_code", err_code, ev.code);
        check("err_count", err_count, ev.cnt);
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Good frame, then bad checksum.
    send4(8'hA5, 8'h95, 8'h80, 8'h15, 3);
    send4(8'hA5, 8'h95, 8'h80, 8'h00, 3);

    // Stall after lo byte, then a fresh frame.
    send(8'hA5, 3); send(8'h95, 3);
    repeat (20) cycle(1'b0, 8'h00);
    send4(8'hA5, 8'h01, 8'h00, 8'h01, 3);

    // Garbage, then a payload made of sync values.
    send(8'h00, 3); send(8'hFF, 3); send(8'h12, 3);
    send4(8'hA5, 8'hA5, 8'hA5, 8'h00, 3);

    // Reset mid-frame.
    send(8'hA5, 3); send(8'h33, 3);
    do_reset();
    send(8'h44, 3);
    send4(8'hA5, 8'h01, 8'h80, 8'h81, 3);

    // Saturate the error counter.
    repeat (260) send4(8'hA5, 8'h01, 8'h02, 8'h00, 0);
    cycle(1'b0, 8'h00);
    check("err_count_sat", err_count, 8'hFF);

    // Bytes landing exactly on the timeout cycle, then one just past it.
    send(8'hA5, 3); send(8'h10, 3); send(8'h20, TIMEOUT - 1); send(8'h30, TIMEOUT - 1);
    send(8'hA5, 3); send(8'h10, 3); send(8'h20, TIMEOUT);

    // Random traffic.
    for (int f = 0; f < 300; f++) begin
      logic [7:0] lo, hi, ck, g;
      int sp;
      if ($urandom_range(3, 0) == 0) begin
        g = 8'($urandom);
        if (g == SYNC) g = 8'h5A;
        send(g, $urandom_range(4, 0));
      end
      lo = 8'($urandom);
      hi = 8'($urandom);
      ck = ($urandom_range(9, 0) < 7) ? (lo ^ hi) : 8'($urandom);
      for (int b = 0; b < 4; b++) begin
        sp = ($urandom_range(7, 0) == 0) ? $urandom_range(18, 13) : $urandom_range(4, 0);
        case (b)
          0: send(SYNC, sp);
          1: send(lo, sp);
          2: send(hi, sp);
          default: send(ck, sp);
        endcase
      end
    end

    repeat (TIMEOUT + 4) cycle(1'b0, 8'h00);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
